// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing a small bank of byte-strobed RW registers.
// Independent write (AW/W -> B) and read (AR -> R) engines; register contents exported flat on reg_out.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 3
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_t;
  typedef enum logic { R_IDLE = 1'b0, R_RESP = 1'b1 } r_state_t;

  function automatic logic idx_mapped(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NUM_REGS);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

  w_state_t              w_state_q,  w_state_d;
  logic                  aw_held_q,  aw_held_d;
  logic                  w_held_q,   w_held_d;
  logic [IDX_W-1:0]      awidx_q,    awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [STRB_W-1:0]     wstrb_q,    wstrb_d;
  logic                  bvalid_q,   bvalid_d;
  logic [1:0]            bresp_q,    bresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  r_state_t              r_state_q,  r_state_d;
  logic                  rvalid_q,   rvalid_d;
  logic [1:0]            rresp_q,    rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s;
  logic                  addr_avail_s, data_avail_s;
  logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;
  logic [DATA_WIDTH-1:0] wr_data_s, rd_word_s;
  logic [STRB_W-1:0]     wr_strb_s;
  logic                  unused_addr_bits_s;

  // Readies come straight from registered state so the master sees them without a cycle of delay.
  assign AWREADY = !ARESET && (w_state_q == W_IDLE) && !aw_held_q;
  assign WREADY  = !ARESET && (w_state_q == W_IDLE) && !w_held_q;
  assign ARREADY = !ARESET && (r_state_q == R_IDLE);

  assign aw_hs_s = AWVALID && AWREADY;
  assign w_hs_s  = WVALID  && WREADY;
  assign ar_hs_s = ARVALID && ARREADY;

  assign addr_avail_s = aw_held_q || aw_hs_s;
  assign data_avail_s = w_held_q  || w_hs_s;
  assign wr_idx_s     = aw_held_q ? awidx_q : AWADDR[ADDR_WIDTH-1:2];
  assign wr_data_s    = w_held_q  ? wdata_q : WDATA;
  assign wr_strb_s    = w_held_q  ? wstrb_q : WSTRB;
  assign rd_idx_s     = ARADDR[ADDR_WIDTH-1:2];

  assign unused_addr_bits_s = ^{AWADDR[1:0], ARADDR[1:0]};

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = rdata_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end
  endgenerate

  // Read mux over the register bank; unmapped indices select nothing and yield zero.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_s == i[IDX_W-1:0]) begin
        rd_word_s = regs_q[i];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Write engine: collect AW and W in either order, commit on the edge both are present.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (addr_avail_s && data_avail_s) begin
          if (idx_mapped(wr_idx_s)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_idx_s == i[IDX_W-1:0]) begin
                regs_d[i] = apply_strb(regs_q[i], wr_data_s, wr_strb_s);
              end else begin
                regs_d[i] = regs_q[i];
              end
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs_s) begin
            awidx_d   = AWADDR[ADDR_WIDTH-1:2];
            aw_held_d = 1'b1;
          end else begin
            awidx_d   = awidx_q;
          end
          if (w_hs_s) begin
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
            w_held_d = 1'b1;
          end else begin
            wdata_d  = wdata_q;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: begin
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Read engine: one beat per AR, held stable until RREADY; RDATA keeps its value while idle.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rdata_d   = rd_word_s;
          rresp_d   = idx_mapped(rd_idx_s) ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          rvalid_d  = 1'b0;
        end
      end
      R_RESP: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d  = 1'b1;
        end
      end
      default: begin
        rvalid_d  = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any half-collected or unacknowledged transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= {IDX_W{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: hand-computed expectations for writes, reads,
// strobes, unmapped accesses, back-pressure, same-edge read/write and mid-transaction reset.
module tb_axi_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RRESP;
  logic [95:0] reg_out;

  int n_cmp = 0;
  int n_err = 0;

  axi_lite_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(3)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
    .reg_out(reg_out)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET = 1'b1; AWADDR = 4'h0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0;
    WVALID = 1'b0; BREADY = 1'b0; ARADDR = 4'h0; ARVALID = 1'b0; RREADY = 1'b0;
    tick(); tick();
    chk("rst_awready", {95'd0, AWREADY}, 96'd0);
    chk("rst_wready",  {95'd0, WREADY},  96'd0);
    chk("rst_arready", {95'd0, ARREADY}, 96'd0);
    chk("rst_bvalid",  {95'd0, BVALID},  96'd0);
    chk("rst_rvalid",  {95'd0, RVALID},  96'd0);
    chk("rst_rdata",   {64'd0, RDATA},   96'd0);
    chk("rst_regs",    reg_out,          96'd0);
    ARESET = 1'b0;
    tick();

    // Same-cycle AW+W to 0x4
    AWADDR = 4'h4; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    #1;
    chk("t1_awready", {95'd0, AWREADY}, 96'd1);
    chk("t1_wready",  {95'd0, WREADY},  96'd1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("t1_bvalid", {95'd0, BVALID}, 96'd1);
    chk("t1_bresp",  {94'd0, BRESP},  96'd0);
    chk("t1_reg1",   {64'd0, reg_out[63:32]}, {64'd0, 32'hDEADBEEF});
    chk("t1_awready_resp", {95'd0, AWREADY}, 96'd0);
    tick();
    chk("t1_bvalid_clr", {95'd0, BVALID}, 96'd0);

    // W first, AW three cycles later, BREADY low to observe W_RESP hold
    BREADY = 1'b0;
    WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1;
    #1;
    chk("t2_wready", {95'd0, WREADY}, 96'd1);
    tick();
    WVALID = 1'b0;
    #1;
    chk("t2_wready_held", {95'd0, WREADY},  96'd0);
    chk("t2_awready_idle", {95'd0, AWREADY}, 96'd1);
    chk("t2_no_bvalid", {95'd0, BVALID}, 96'd0);
    tick(); tick();
    AWADDR = 4'h0; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    #1;
    chk("t2_bvalid", {95'd0, BVALID}, 96'd1);
    chk("t2_reg0",   {64'd0, reg_out[31:0]}, {64'd0, 32'h00220044});
    chk("t2_awready_resp", {95'd0, AWREADY}, 96'd0);
    tick();
    chk("t2_bvalid_hold", {95'd0, BVALID}, 96'd1);
    chk("t2_wready_resp", {95'd0, WREADY}, 96'd0);
    BREADY = 1'b1;
    tick();
    chk("t2_bvalid_clr", {95'd0, BVALID}, 96'd0);

    // AW first, then partial-strobe W to 0x4: DEADBEEF -> DEAD77EF
    AWADDR = 4'h4; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    #1;
    chk("t3_awready_held", {95'd0, AWREADY}, 96'd0);
    WDATA = 32'h00007700; WSTRB = 4'h2; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    #1;
    chk("t3_bvalid", {95'd0, BVALID}, 96'd1);
    chk("t3_reg1",   {64'd0, reg_out[63:32]}, {64'd0, 32'hDEAD77EF});
    tick();

    // Unmapped write to 0xC
    AWADDR = 4'hC; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("t4_bvalid", {95'd0, BVALID}, 96'd1);
    chk("t4_bresp",  {94'd0, BRESP},  96'd2);
    chk("t4_regs",   reg_out, {32'h0, 32'hDEAD77EF, 32'h00220044});
    tick();

    // Read 0x4 with RREADY low for 5 cycles
    ARADDR = 4'h4; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    chk("t5_arready", {95'd0, ARREADY}, 96'd1);
    tick();
    ARVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_rvalid",  {95'd0, RVALID},  96'd1);
      chk("t5_rdata",   {64'd0, RDATA},   {64'd0, 32'hDEAD77EF});
      chk("t5_rresp",   {94'd0, RRESP},   96'd0);
      chk("t5_arready_busy", {95'd0, ARREADY}, 96'd0);
      tick();
    end
    RREADY = 1'b1;
    tick();
    chk("t5_rvalid_clr", {95'd0, RVALID}, 96'd0);
    chk("t5_rdata_keep", {64'd0, RDATA},  {64'd0, 32'hDEAD77EF});
    chk("t5_arready_idle", {95'd0, ARREADY}, 96'd1);
    RREADY = 1'b0;

    // Unmapped read 0xC
    ARADDR = 4'hC; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    #1;
    chk("t6_rvalid", {95'd0, RVALID}, 96'd1);
    chk("t6_rdata",  {64'd0, RDATA},  96'd0);
    chk("t6_rresp",  {94'd0, RRESP},  96'd2);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

    // Same-edge read and write to 0x8
    AWADDR = 4'h8; AWVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 4'h8; ARVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    #1;
    chk("t7_rvalid", {95'd0, RVALID}, 96'd1);
    chk("t7_rdata_old", {64'd0, RDATA}, 96'd0);
    chk("t7_rresp", {94'd0, RRESP}, 96'd0);
    chk("t7_bvalid", {95'd0, BVALID}, 96'd1);
    chk("t7_reg2", {64'd0, reg_out[95:64]}, {64'd0, 32'hA5A5A5A5});
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("t7_rvalid_clr", {95'd0, RVALID}, 96'd0);
    chk("t7_bvalid_clr", {95'd0, BVALID}, 96'd0);

    // Reset while BVALID pending
    BREADY = 1'b0;
    AWADDR = 4'h0; AWVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("t8_bvalid_pre", {95'd0, BVALID}, 96'd1);
    ARESET = 1'b1;
    tick();
    chk("t8_bvalid_rst", {95'd0, BVALID}, 96'd0);
    chk("t8_regs_rst",   reg_out, 96'd0);
    chk("t8_awready_rst", {95'd0, AWREADY}, 96'd0);
    ARESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t8_no_late_bvalid", {95'd0, BVALID}, 96'd0);
    end
    chk("t8_awready_post", {95'd0, AWREADY}, 96'd1);

    // Held AW dropped by reset: a later lone W must not complete a write
    AWADDR = 4'h4; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    tick();
    chk("t9_no_bvalid", {95'd0, BVALID}, 96'd0);
    chk("t9_regs", reg_out, 96'd0);
    AWADDR = 4'h4; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    #1;
    chk("t9_bvalid", {95'd0, BVALID}, 96'd1);
    chk("t9_reg1", {64'd0, reg_out[63:32]}, {64'd0, 32'hCAFEF00D});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
